// File: rtl/mult_check_engine.sv
// Shift-add self-checking engine: recomputes a*b over WIDTH cycles, compares it against
// the product reported by a candidate multiplier, and keeps pass/fail statistics.
module mult_check_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2*WIDTH-1:0] in_p,
  input  logic               clear_cnt,
  output logic               res_valid,
  output logic               res_mismatch,
  output logic [2*WIDTH-1:0] res_expected,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic               fail_seen,
  output logic [WIDTH-1:0]   first_fail_a,
  output logic [WIDTH-1:0]   first_fail_b,
  output logic [2*WIDTH-1:0] first_fail_p
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [PW-1:0]     p_lat_q, p_lat_d;
  logic [WIDTH-1:0]  a_lat_q, a_lat_d;
  logic [WIDTH-1:0]  b_lat_q, b_lat_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              res_valid_q, res_valid_d;
  logic              res_mismatch_q, res_mismatch_d;
  logic [PW-1:0]     res_expected_q, res_expected_d;
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic              fail_seen_q, fail_seen_d;
  logic [WIDTH-1:0]  ff_a_q, ff_a_d;
  logic [WIDTH-1:0]  ff_b_q, ff_b_d;
  logic [PW-1:0]     ff_p_q, ff_p_d;

  logic [PW-1:0]     acc_next;
  logic              done;
  logic              mismatch_now;

  always_comb begin
    acc_next     = acc_q + (b_sh_q[0] ? a_sh_q : '0);
    done         = (state_q == MUL) && (cnt_q == CW'(WIDTH - 1));
    mismatch_now = (acc_next != p_lat_q);

    state_d        = state_q;
    a_sh_d         = a_sh_q;
    b_sh_d         = b_sh_q;
    p_lat_d        = p_lat_q;
    a_lat_d        = a_lat_q;
    b_lat_d        = b_lat_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    res_valid_d    = 1'b0;
    res_mismatch_d = res_mismatch_q;
    res_expected_d = res_expected_q;
    pass_cnt_d     = pass_cnt_q;
    fail_cnt_d     = fail_cnt_q;
    fail_seen_d    = fail_seen_q;
    ff_a_d         = ff_a_q;
    ff_b_d         = ff_b_q;
    ff_p_d         = ff_p_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = {{WIDTH{1'b0}}, in_a};
          b_sh_d  = in_b;
          p_lat_d = in_p;
          a_lat_d = in_a;
          b_lat_d = in_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d  = acc_next;
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (done) begin
          state_d        = IDLE;
          res_valid_d    = 1'b1;
          res_mismatch_d = mismatch_now;
          res_expected_d = acc_next;
          if (!mismatch_now) begin
            if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
          end else begin
            if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
            if (!fail_seen_q) begin
              fail_seen_d = 1'b1;
              ff_a_d      = a_lat_q;
              ff_b_d      = b_lat_q;
              ff_p_d      = p_lat_q;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over a same-edge completion; the result itself is still reported.
    if (clear_cnt) begin
      pass_cnt_d  = '0;
      fail_cnt_d  = '0;
      fail_seen_d = 1'b0;
      ff_a_d      = '0;
      ff_b_d      = '0;
      ff_p_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      a_sh_q         <= '0;
      b_sh_q         <= '0;
      p_lat_q        <= '0;
      a_lat_q        <= '0;
      b_lat_q        <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      res_valid_q    <= 1'b0;
      res_mismatch_q <= 1'b0;
      res_expected_q <= '0;
      pass_cnt_q     <= '0;
      fail_cnt_q     <= '0;
      fail_seen_q    <= 1'b0;
      ff_a_q         <= '0;
      ff_b_q         <= '0;
      ff_p_q         <= '0;
    end else begin
      state_q        <= state_d;
      a_sh_q         <= a_sh_d;
      b_sh_q         <= b_sh_d;
      p_lat_q        <= p_lat_d;
      a_lat_q        <= a_lat_d;
      b_lat_q        <= b_lat_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      res_valid_q    <= res_valid_d;
      res_mismatch_q <= res_mismatch_d;
      res_expected_q <= res_expected_d;
      pass_cnt_q     <= pass_cnt_d;
      fail_cnt_q     <= fail_cnt_d;
      fail_seen_q    <= fail_seen_d;
      ff_a_q         <= ff_a_d;
      ff_b_q         <= ff_b_d;
      ff_p_q         <= ff_p_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign res_valid    = res_valid_q;
  assign res_mismatch = res_mismatch_q;
  assign res_expected = res_expected_q;
  assign pass_cnt     = pass_cnt_q;
  assign fail_cnt     = fail_cnt_q;
  assign fail_seen    = fail_seen_q;
  assign first_fail_a = ff_a_q;
  assign first_fail_b = ff_b_q;
  assign first_fail_p = ff_p_q;

endmodule
